// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Multi-cycle control FSM for the MC-CPU datapath. Decodes the
//               IR opcode (and the ALU zero flag for branches), sequences
//               IF/ID/EXE/MEM/WB, drives every datapath control input and
//               counts retired instructions (one per PCWre pulse).
//               Optional feature macro: HALT_EN (adds the HALT state and
//               the 111111 halt opcode; otherwise 111111 is a NOP).
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       decode,
  input  logic             zero,
  output logic             PCWre,
  output logic             IRWre,
  output logic             InsMemRW,
  output logic             RegWre,
  output logic [1:0]       RegOut,
  output logic             WrRegData,
  output logic             ALUSrcB,
  output logic             ExtSel,
  output logic [2:0]       ALUOp,
  output logic             ALUM2Reg,
  output logic             DataMemRw,
  output logic [1:0]       PCSrc,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             halted
);

  // Opcodes (IR[31:26])
  localparam logic [5:0] c_OP_ADD  = 6'b000000;
  localparam logic [5:0] c_OP_SUB  = 6'b000001;
  localparam logic [5:0] c_OP_ADDI = 6'b000010;
  localparam logic [5:0] c_OP_ORI  = 6'b010000;
  localparam logic [5:0] c_OP_AND  = 6'b010001;
  localparam logic [5:0] c_OP_OR   = 6'b010010;
  localparam logic [5:0] c_OP_SLT  = 6'b100110;
  localparam logic [5:0] c_OP_SW   = 6'b110000;
  localparam logic [5:0] c_OP_LW   = 6'b110001;
  localparam logic [5:0] c_OP_BEQ  = 6'b110100;
  localparam logic [5:0] c_OP_J    = 6'b111000;
  localparam logic [5:0] c_OP_JR   = 6'b111001;
  localparam logic [5:0] c_OP_JAL  = 6'b111010;
`ifdef HALT_EN
  localparam logic [5:0] c_OP_HALT = 6'b111111;
`endif

  // ALU operation codes
  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_SLT = 3'b010;
  localparam logic [2:0] c_ALU_OR  = 3'b011;
  localparam logic [2:0] c_ALU_AND = 3'b100;

  // Explicitly encoded states; the encoding is visible on the debug port
  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_IF     = 4'd1,
    S_ID     = 4'd2,
    S_EXE_AL = 4'd3,
    S_EXE_BR = 4'd4,
    S_EXE_LS = 4'd5,
    S_MEM_LD = 4'd6,
    S_MEM_ST = 4'd7,
    S_WB_AL  = 4'd8,
    S_WB_LD  = 4'd9
`ifdef HALT_EN
    ,
    S_HALT   = 4'd10
`endif
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_instr_cnt;

  // Opcode classification and the ALU controls each ALU/memory op needs
  logic       w_op_alu;
  logic       w_op_rtype;
  logic       w_op_beq;
  logic       w_op_lw;
  logic       w_op_sw;
  logic       w_op_j;
  logic       w_op_jal;
  logic       w_op_jr;
`ifdef HALT_EN
  logic       w_op_halt;
`endif
  logic [2:0] w_alu_ctl;
  logic       w_alu_srcb;
  logic       w_ext_sel;

  // Decode the opcode into instruction classes and ALU settings
  always_comb begin
    w_op_alu   = 1'b0;
    w_op_rtype = 1'b0;
    w_op_beq   = 1'b0;
    w_op_lw    = 1'b0;
    w_op_sw    = 1'b0;
    w_op_j     = 1'b0;
    w_op_jal   = 1'b0;
    w_op_jr    = 1'b0;
`ifdef HALT_EN
    w_op_halt  = 1'b0;
`endif
    w_alu_ctl  = c_ALU_ADD;
    w_alu_srcb = 1'b0;
    w_ext_sel  = 1'b0;
    case (decode)
      c_OP_ADD:  begin w_op_alu = 1'b1; w_op_rtype = 1'b1; w_alu_ctl = c_ALU_ADD; end
      c_OP_SUB:  begin w_op_alu = 1'b1; w_op_rtype = 1'b1; w_alu_ctl = c_ALU_SUB; end
      c_OP_AND:  begin w_op_alu = 1'b1; w_op_rtype = 1'b1; w_alu_ctl = c_ALU_AND; end
      c_OP_OR:   begin w_op_alu = 1'b1; w_op_rtype = 1'b1; w_alu_ctl = c_ALU_OR;  end
      c_OP_SLT:  begin w_op_alu = 1'b1; w_op_rtype = 1'b1; w_alu_ctl = c_ALU_SLT; end
      c_OP_ADDI: begin
        w_op_alu   = 1'b1;
        w_alu_ctl  = c_ALU_ADD;
        w_alu_srcb = 1'b1;
        w_ext_sel  = 1'b1;
      end
      c_OP_ORI:  begin
        w_op_alu   = 1'b1;
        w_alu_ctl  = c_ALU_OR;
        w_alu_srcb = 1'b1;
      end
      // Loads and stores compute base + sign-extended offset
      c_OP_LW:   begin w_op_lw = 1'b1; w_alu_srcb = 1'b1; w_ext_sel = 1'b1; end
      c_OP_SW:   begin w_op_sw = 1'b1; w_alu_srcb = 1'b1; w_ext_sel = 1'b1; end
      c_OP_BEQ:  w_op_beq = 1'b1;
      c_OP_J:    w_op_j   = 1'b1;
      c_OP_JAL:  w_op_jal = 1'b1;
      c_OP_JR:   w_op_jr  = 1'b1;
`ifdef HALT_EN
      c_OP_HALT: w_op_halt = 1'b1;
`endif
      default:   ;
    endcase
  end

  // State register; reset aborts any in-flight instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_RST;
    else        r_state <= w_next_state;
  end

  // Next-state and control outputs from current state and opcode
  always_comb begin
    w_next_state = r_state;
    PCWre        = 1'b0;
    IRWre        = 1'b0;
    RegWre       = 1'b0;
    RegOut       = 2'b00;
    WrRegData    = 1'b0;
    ALUSrcB      = 1'b0;
    ExtSel       = 1'b0;
    ALUOp        = 3'b000;
    ALUM2Reg     = 1'b0;
    DataMemRw    = 1'b0;
    PCSrc        = 2'b00;
    case (r_state)
      S_RST: w_next_state = S_IF;
      S_IF: begin
        IRWre        = 1'b1;
        w_next_state = S_ID;
      end
      S_ID: begin
        if (w_op_j || w_op_jal) begin
          PCSrc        = 2'b11;
          PCWre        = 1'b1;
          // JAL links the current PC+4 into $31 while jumping
          RegWre       = w_op_jal;
          w_next_state = S_IF;
        end else if (w_op_jr) begin
          PCSrc        = 2'b10;
          PCWre        = 1'b1;
          w_next_state = S_IF;
        end else if (w_op_alu) begin
          w_next_state = S_EXE_AL;
        end else if (w_op_beq) begin
          w_next_state = S_EXE_BR;
        end else if (w_op_lw || w_op_sw) begin
          w_next_state = S_EXE_LS;
`ifdef HALT_EN
        end else if (w_op_halt) begin
          w_next_state = S_HALT;
`endif
        end else begin
          // Unknown opcode retires as a NOP
          PCWre        = 1'b1;
          w_next_state = S_IF;
        end
      end
      S_EXE_AL: begin
        ALUOp        = w_alu_ctl;
        ALUSrcB      = w_alu_srcb;
        ExtSel       = w_ext_sel;
        w_next_state = S_WB_AL;
      end
      S_WB_AL: begin
        ALUOp        = w_alu_ctl;
        ALUSrcB      = w_alu_srcb;
        ExtSel       = w_ext_sel;
        RegWre       = 1'b1;
        WrRegData    = 1'b1;
        RegOut       = w_op_rtype ? 2'b10 : 2'b01;
        PCWre        = 1'b1;
        w_next_state = S_IF;
      end
      S_EXE_BR: begin
        ALUOp        = c_ALU_SUB;
        PCSrc        = zero ? 2'b01 : 2'b00;
        PCWre        = 1'b1;
        w_next_state = S_IF;
      end
      S_EXE_LS: begin
        ALUOp        = w_alu_ctl;
        ALUSrcB      = w_alu_srcb;
        ExtSel       = w_ext_sel;
        w_next_state = w_op_lw ? S_MEM_LD : S_MEM_ST;
      end
      S_MEM_ST: begin
        ALUOp        = w_alu_ctl;
        ALUSrcB      = w_alu_srcb;
        ExtSel       = w_ext_sel;
        DataMemRw    = 1'b1;
        PCWre        = 1'b1;
        w_next_state = S_IF;
      end
      S_MEM_LD: begin
        ALUOp        = w_alu_ctl;
        ALUSrcB      = w_alu_srcb;
        ExtSel       = w_ext_sel;
        ALUM2Reg     = 1'b1;
        w_next_state = S_WB_LD;
      end
      S_WB_LD: begin
        ALUOp        = w_alu_ctl;
        ALUSrcB      = w_alu_srcb;
        ExtSel       = w_ext_sel;
        ALUM2Reg     = 1'b1;
        RegWre       = 1'b1;
        RegOut       = 2'b01;
        WrRegData    = 1'b1;
        PCWre        = 1'b1;
        w_next_state = S_IF;
      end
`ifdef HALT_EN
      // Parked with every enable low until reset
      S_HALT: w_next_state = S_HALT;
`endif
      default: w_next_state = S_RST;
    endcase
  end

  // Retired-instruction counter: one count per PC update, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_instr_cnt <= '0;
    else if (PCWre) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
  end

  assign InsMemRW  = 1'b1;
  assign state     = r_state;
  assign instr_cnt = r_instr_cnt;
`ifdef HALT_EN
  assign halted    = (r_state == S_HALT);
`else
  assign halted    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Scoreboard bench for mc_control_fsm. Each instruction issued
//               expands into its per-cycle control vectors from the
//               instruction-level recipe; a monitor pops one vector per
//               cycle and compares it with the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  decode = 6'b0;
  logic        zero = 1'b0;
  logic        PCWre, IRWre, InsMemRW, RegWre, WrRegData, ALUSrcB, ExtSel;
  logic        ALUM2Reg, DataMemRw, halted;
  logic [1:0]  RegOut, PCSrc;
  logic [2:0]  ALUOp;
  logic [3:0]  state;
  logic [31:0] instr_cnt;

  mc_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .decode(decode), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
    .RegOut(RegOut), .WrRegData(WrRegData), .ALUSrcB(ALUSrcB),
    .ExtSel(ExtSel), .ALUOp(ALUOp), .ALUM2Reg(ALUM2Reg),
    .DataMemRw(DataMemRw), .PCSrc(PCSrc), .state(state),
    .instr_cnt(instr_cnt), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pcwre;
    logic        irwre;
    logic        insmem;
    logic        regwre;
    logic [1:0]  regout;
    logic        wrreg;
    logic        alusrcb;
    logic        extsel;
    logic [2:0]  aluop;
    logic        m2reg;
    logic        dmw;
    logic [1:0]  pcsrc;
    logic        halted;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    vec_t       v;
    logic [5:0] op;
    int         step;
  } item_t;

  item_t       scb[$];
  vec_t        seq[$];
  item_t       mon_it;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt = 32'd0;
  logic [5:0]  known [13] = '{6'b000000, 6'b000001, 6'b010001, 6'b010010,
                             6'b100110, 6'b000010, 6'b010000, 6'b110000,
                             6'b110001, 6'b110100, 6'b111000, 6'b111001,
                             6'b111010};

  function automatic vec_t actual();
    vec_t a;
    a = '{PCWre, IRWre, InsMemRW, RegWre, RegOut, WrRegData, ALUSrcB, ExtSel,
          ALUOp, ALUM2Reg, DataMemRw, PCSrc, halted, instr_cnt};
    return a;
  endfunction

  function automatic vec_t base();
    vec_t b;
    b = '0;
    b.insmem = 1'b1;
    return b;
  endfunction

  task automatic check(input string name, input vec_t exp);
    vec_t a;
    a = actual();
    checks++;
    if (a !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, a, exp);
    end
  endtask

  // Append one cycle of expected controls; a PC update retires an instruction
  function automatic void add(input vec_t v);
    vec_t t;
    t = v;
    t.cnt = model_cnt;
    seq.push_back(t);
    if (t.pcwre) model_cnt = model_cnt + 32'd1;
  endfunction

  // Instruction-level reference: the cycle-by-cycle controls of one opcode
  function automatic void make_seq(input logic [5:0] op, input logic z);
    vec_t       v;
    logic [2:0] ao;
    logic       srcb, ext;
    logic [1:0] dst;
    seq.delete();
    v = base();
    v.irwre = 1'b1;
    add(v);                                   // fetch
    v = base();
    ao = 3'b000; srcb = 1'b0; ext = 1'b0; dst = 2'b10;
    case (op)
      6'b000000, 6'b000001, 6'b010001, 6'b010010, 6'b100110,
      6'b000010, 6'b010000: begin
        case (op)
          6'b000001: ao = 3'b001;
          6'b010001: ao = 3'b100;
          6'b010010: ao = 3'b011;
          6'b100110: ao = 3'b010;
          6'b000010: begin ao = 3'b000; srcb = 1'b1; ext = 1'b1; dst = 2'b01; end
          6'b010000: begin ao = 3'b011; srcb = 1'b1; dst = 2'b01; end
          default:   ao = 3'b000;
        endcase
        add(base());
        v.aluop = ao; v.alusrcb = srcb; v.extsel = ext;
        add(v);
        v.regwre = 1'b1; v.wrreg = 1'b1; v.regout = dst; v.pcwre = 1'b1;
        add(v);
      end
      6'b110100: begin
        add(base());
        v.aluop = 3'b001;
        v.pcsrc = z ? 2'b01 : 2'b00;
        v.pcwre = 1'b1;
        add(v);
      end
      6'b110001: begin
        add(base());
        v.alusrcb = 1'b1; v.extsel = 1'b1;
        add(v);
        v.m2reg = 1'b1;
        add(v);
        v.regwre = 1'b1; v.regout = 2'b01; v.wrreg = 1'b1; v.pcwre = 1'b1;
        add(v);
      end
      6'b110000: begin
        add(base());
        v.alusrcb = 1'b1; v.extsel = 1'b1;
        add(v);
        v.dmw = 1'b1; v.pcwre = 1'b1;
        add(v);
      end
      6'b111000: begin v.pcsrc = 2'b11; v.pcwre = 1'b1; add(v); end
      6'b111010: begin v.pcsrc = 2'b11; v.pcwre = 1'b1; v.regwre = 1'b1; add(v); end
      6'b111001: begin v.pcsrc = 2'b10; v.pcwre = 1'b1; add(v); end
`ifdef HALT_EN
      6'b111111: add(base());
`endif
      default:   begin v.pcwre = 1'b1; add(v); end
    endcase
  endfunction

  task automatic push_seq(input logic [5:0] op, input int n);
    item_t it;
    for (int i = 0; i < n; i++) begin
      it.v = seq[i]; it.op = op; it.step = i;
      scb.push_back(it);
    end
  endtask

  // Called at posedge+1 with the DUT in IF; returns at posedge+1 of next IF
  task automatic run_instr(input logic [5:0] op, input logic z);
    int n;
    decode = op;
    zero   = z;
    make_seq(op, z);
    n = seq.size();
    push_seq(op, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Assert reset, verify the cleared outputs, release into RST then IF
  task automatic pulse_reset();
    vec_t r;
    r = base();
    reset = 1'b0;
    #1 check("reset_async", r);
    @(posedge clk);
    #1 check("reset_hold", r);
    reset = 1'b1;
    model_cnt = 32'd0;
    seq.delete();
    add(base());                              // RST cycle
    push_seq(6'b0, 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expected vector per cycle while the scoreboard holds any
  always @(negedge clk) begin
    if (scb.size() > 0) begin
      mon_it = scb.pop_front();
      check($sformatf("op%b_step%0d", mon_it.op, mon_it.step), mon_it.v);
    end
  end

  initial begin
    logic [5:0] op;
    vec_t       hv;
    #2;
    pulse_reset();

    // Directed instructions
    run_instr(6'b000000, 1'b0);   // ADD
    run_instr(6'b110100, 1'b1);   // BEQ taken
    run_instr(6'b110100, 1'b0);   // BEQ not taken
    run_instr(6'b110001, 1'b0);   // LW
    run_instr(6'b110000, 1'b1);   // SW
    run_instr(6'b111010, 1'b0);   // JAL
    run_instr(6'b111000, 1'b1);   // J
    run_instr(6'b111001, 1'b0);   // JR
    run_instr(6'b101010, 1'b0);   // unknown -> NOP
    run_instr(6'b000010, 1'b1);   // ADDI
    run_instr(6'b010000, 1'b0);   // ORI
    run_instr(6'b100110, 1'b1);   // SLT
`ifndef HALT_EN
    run_instr(6'b111111, 1'b0);   // halt opcode is a NOP in this build
`endif

    // Reset during EXE_LS of SW: no store pulse, counter cleared
    decode = 6'b110000;
    make_seq(6'b110000, 1'b0);
    push_seq(6'b110000, 3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    pulse_reset();

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) op = known[$urandom_range(0, 12)];
      else                           op = 6'($urandom_range(0, 63));
`ifdef HALT_EN
      if (op == 6'b111111) op = 6'b101010;
`endif
      run_instr(op, 1'($urandom_range(0, 1)));
    end

`ifdef HALT_EN
    // HALT parks with all enables low and a frozen counter until reset
    decode = 6'b111111;
    make_seq(6'b111111, 1'b0);
    hv = base();
    hv.halted = 1'b1;
    for (int i = 0; i < 5; i++) add(hv);
    push_seq(6'b111111, 7);
    repeat (7) @(posedge clk);
    #1;
    pulse_reset();
    run_instr(6'b000000, 1'b0);
`else
    hv = base();
`endif

    run_instr(6'b110001, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (scb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", scb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
